// File: rtl/vscale_dmem_slave_pkg.sv
// Shared HASTI constants, slave FSM state type and byte-lane helpers for the
// shared data-memory slave.
package vscale_dmem_slave_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_BUS_NBYTES  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALF = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD = 3'd2;

  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_XFER = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } dmem_state_e;

  // Lanes touched by a transfer; only meaningful for aligned, legal sizes.
  function automatic logic [HASTI_BUS_NBYTES-1:0] byte_mask(
    input logic [HASTI_SIZE_WIDTH-1:0] size,
    input logic [1:0]                  off
  );
    case (size)
      HASTI_SIZE_BYTE: byte_mask = 4'b0001 << off;
      HASTI_SIZE_HALF: byte_mask = 4'b0011 << off;
      HASTI_SIZE_WORD: byte_mask = 4'b1111;
      default:         byte_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic align_error(
    input logic [HASTI_SIZE_WIDTH-1:0] size,
    input logic [1:0]                  off
  );
    case (size)
      HASTI_SIZE_BYTE: align_error = 1'b0;
      HASTI_SIZE_HALF: align_error = off[0];
      HASTI_SIZE_WORD: align_error = (off != 2'd0);
      default:         align_error = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/vscale_dmem_bank.sv
// Word-organised storage: byte-enabled bus write port, backdoor word write
// port that yields to the bus on overlapping lanes, combinational read.
module vscale_dmem_bank
  import vscale_dmem_slave_pkg::*;
#(
  parameter int NUM_WORDS = 32
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [HASTI_BUS_NBYTES-1:0]       be,
  input  logic [$clog2(NUM_WORDS)-1:0]      waddr,
  input  logic [HASTI_BUS_WIDTH-1:0]        wdata,
  input  logic [$clog2(NUM_WORDS)-1:0]      raddr,
  output logic [HASTI_BUS_WIDTH-1:0]        rdata,
  input  logic                              bd_we,
  input  logic [4:0]                        bd_addr,
  input  logic [31:0]                       bd_data
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  logic [HASTI_BUS_WIDTH-1:0] mem_r [NUM_WORDS];
  logic [IDX_W-1:0]           bd_idx_s;

  assign bd_idx_s = IDX_W'(bd_addr);
  assign rdata    = mem_r[raddr];

  // Storage update; the bus lanes are assigned last so they win a collision.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem_r[bd_idx_s] <= bd_data;
    end
    if (we) begin
      for (int b = 0; b < HASTI_BUS_NBYTES; b++) begin
        if (be[b]) begin
          mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/vscale_dmem_slave.sv
// HASTI data-memory slave: address-phase capture, error decode, wait-state
// and two-cycle error FSM, byte-mask generation around a vscale_dmem_bank.
module vscale_dmem_slave
  import vscale_dmem_slave_pkg::*;
#(
  parameter int NUM_WORDS   = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [HASTI_ADDR_WIDTH-1:0]   haddr,
  input  logic                          hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]   hsize,
  input  logic [HASTI_BURST_WIDTH-1:0]  hburst,
  input  logic                          hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]   hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0]  htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]    hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]    hrdata,
  output logic                          hready,
  output logic [HASTI_RESP_WIDTH-1:0]   hresp,
  input  logic                          i_we,
  input  logic [4:0]                    i_addr,
  input  logic [31:0]                   i_data
);

  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int IDX_HI = IDX_W + 1;
  localparam logic [2:0] WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  dmem_state_e                  state_r, state_s;
  logic [2:0]                   wait_cnt_r, wait_cnt_s;
  logic [IDX_W-1:0]             idx_r;
  logic [1:0]                   off_r;
  logic [HASTI_SIZE_WIDTH-1:0]  size_r;
  logic                         write_r;

  logic                         hready_s;
  logic [HASTI_RESP_WIDTH-1:0]  hresp_s;
  logic                         accept_s;
  logic                         req_err_s;
  logic                         bus_we_s;
  logic [HASTI_BUS_NBYTES-1:0]  bmask_s;
  logic [HASTI_BUS_WIDTH-1:0]   rd_data_s;
  logic                         unused_s;

  assign unused_s  = ^{hburst, hmastlock, hprot};
  assign accept_s  = hready_s && ((htrans == HASTI_TRANS_NONSEQ) || (htrans == HASTI_TRANS_SEQ));
  assign req_err_s = ((haddr >> (IDX_HI + 1)) != 32'd0) || align_error(hsize, haddr[1:0]);

  // Next-state and wait counter; the counter is loaded on entry to WAIT.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      ST_IDLE, ST_XFER, ST_ERR2: begin
        if (accept_s) begin
          if (req_err_s) begin
            state_s = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_s    = ST_WAIT;
            wait_cnt_s = WS_INIT;
          end else begin
            state_s = ST_XFER;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == 3'd0) begin
          state_s = ST_XFER;
        end else begin
          wait_cnt_s = wait_cnt_r - 3'd1;
        end
      end
      ST_ERR1: state_s = ST_ERR2;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counter and address-phase capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 3'd0;
      idx_r      <= '0;
      off_r      <= 2'd0;
      size_r     <= 3'd0;
      write_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      if (accept_s) begin
        idx_r   <= haddr[IDX_HI:2];
        off_r   <= haddr[1:0];
        size_r  <= hsize;
        write_r <= hwrite;
      end
    end
  end

  // Bus response decoded from the registered state.
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = HASTI_RESP_OKAY;
    hrdata   = '0;
    case (state_r)
      ST_WAIT: hready_s = 1'b0;
      ST_ERR1: begin
        hready_s = 1'b0;
        hresp_s  = HASTI_RESP_ERROR;
      end
      ST_ERR2: hresp_s = HASTI_RESP_ERROR;
      ST_XFER: hrdata  = rd_data_s;
      default: hready_s = 1'b1;
    endcase
  end

  assign hready   = hready_s;
  assign hresp    = hresp_s;
  assign bmask_s  = byte_mask(size_r, off_r);
  assign bus_we_s = (state_r == ST_XFER) && write_r && !reset;

  vscale_dmem_bank #(
    .NUM_WORDS (NUM_WORDS)
  ) u_bank (
    .clk     (clk),
    .we      (bus_we_s),
    .be      (bmask_s),
    .waddr   (idx_r),
    .wdata   (hwdata),
    .raddr   (idx_r),
    .rdata   (rd_data_s),
    .bd_we   (i_we),
    .bd_addr (i_addr),
    .bd_data (i_data)
  );

endmodule
